game_flow_ctrl: RTL and testbench

GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

---
 rtl/game_flow_ctrl_if.sv | 29 ++
 rtl/game_flow_ctrl.sv | 174 +++++++++++++++++
 tb/tb_game_flow_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/game_flow_ctrl_if.sv
// Game flow controller event/status bundle.
// master drives the event pulses, slave is the controller.
interface game_flow_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic                  tick;
  logic                  enemy_kill;
  logic                  boss_hit;
  logic                  player_hit;
  logic                  collision;
  logic [2:0]            state;
  logic                  play_en;
  logic                  boss_en;
  logic [4*DIGITS-1:0]   score;
  logic [3:0]            lives;
  logic [3:0]            boss_hp;
  logic                  invuln;

  modport master (
    output start, tick, enemy_kill, boss_hit, player_hit, collision,
    input  state, play_en, boss_en, score, lives, boss_hp, invuln
  );

  modport slave (
    input  start, tick, enemy_kill, boss_hit, player_hit, collision,
    output state, play_en, boss_en, score, lives, boss_hp, invuln
  );
endinterface

// File: rtl/game_flow_ctrl.sv
// Game flow FSM: BCD score, lives, boss phase, win/over hold states.
// Define GAME_FLOW_INVULN_EN to add the post-hit grace window.
module game_flow_ctrl #(
  parameter int DIGITS       = 4,
  parameter int LIVES        = 3,
  parameter int BOSS_KILLS   = 10,
  parameter int BOSS_HP      = 8,
  parameter int PTS_ENEMY    = 1,
  parameter int PTS_BOSS     = 5,
  parameter int INVULN_TICKS = 100
) (
  input  logic              clk,
  input  logic              rst,
  game_flow_ctrl_if.slave   bus
);
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PLAY = 3'd1,
    BOSS = 3'd2,
    OVER = 3'd3,
    WIN  = 3'd4
  } state_t;

  localparam int SW = 4*DIGITS;
  localparam int SUM_EB = PTS_ENEMY + PTS_BOSS;
  localparam logic [7:0] ADD_E  = 8'(PTS_ENEMY);
  localparam logic [7:0] ADD_B  = 8'(PTS_BOSS);
  localparam logic [7:0] ADD_EB = 8'(((SUM_EB / 10) << 4) | (SUM_EB % 10));

  state_t        state_q, state_nxt;
  logic [SW-1:0] score_q, score_nxt;
  logic [3:0]    lives_q, lives_nxt;
  logic [3:0]    hp_q, hp_nxt;
  logic [7:0]    kills_q, kills_nxt;
  logic          play_en_q, boss_en_q;
  logic          invuln_q;
  logic          active, kill, bhit, hit_ok;
  logic [7:0]    add;

  // b is a two-digit BCD addend; a carry out of the top digit saturates
  function automatic logic [SW-1:0] bcd_add(
    input logic [SW-1:0] a,
    input logic [7:0]    b
  );
    logic [SW-1:0] r;
    logic [4:0]    s;
    logic [3:0]    bd;
    logic          c;
    r = '0;
    c = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      bd = 4'd0;
      if (i == 0) bd = b[3:0];
      else if (i == 1) bd = b[7:4];
      s = 5'(a[4*i +: 4]) + 5'(bd) + 5'(c);
      if (s > 5'd9) begin
        r[4*i +: 4] = 4'(s - 5'd10);
        c = 1'b1;
      end else begin
        r[4*i +: 4] = s[3:0];
        c = 1'b0;
      end
    end
    if (c || (DIGITS == 1 && b[7:4] != 4'd0))
      r = {DIGITS{4'h9}};
    return r;
  endfunction

`ifdef GAME_FLOW_INVULN_EN
  logic [9:0] grace_q, grace_nxt;
`else
  logic unused_tick;
  assign unused_tick = bus.tick;
  assign invuln_q    = 1'b0;
`endif

  always_comb begin
    state_nxt = state_q;
    score_nxt = score_q;
    lives_nxt = lives_q;
    hp_nxt    = hp_q;
    kills_nxt = kills_q;
    active    = (state_q == PLAY) || (state_q == BOSS);
    kill      = active && bus.enemy_kill;
    bhit      = (state_q == BOSS) && bus.boss_hit;
    hit_ok    = active && bus.player_hit &&
                (lives_q != 4'd0) && !invuln_q;
    add       = 8'h00;

    unique case (state_q)
      IDLE: if (bus.start) begin
        state_nxt = PLAY;
        score_nxt = '0;
        lives_nxt = 4'(LIVES);
        hp_nxt    = 4'(BOSS_HP);
        kills_nxt = '0;
      end
      OVER, WIN: if (bus.start) state_nxt = IDLE;
      default: ;
    endcase

    unique case (1'b1)
      kill && bhit:  add = ADD_EB;
      kill && !bhit: add = ADD_E;
      !kill && bhit: add = ADD_B;
      default:       add = 8'h00;
    endcase

    if (active) begin
      if (kill || bhit) score_nxt = bcd_add(score_q, add);
      if (kill && kills_q != 8'hff) kills_nxt = kills_q + 8'd1;
      if (bhit && hp_q != 4'd0) hp_nxt = hp_q - 4'd1;
      if (hit_ok) lives_nxt = lives_q - 4'd1;
      if (bus.collision) lives_nxt = 4'd0;
      // loss outranks a coinciding win or boss entry
      if (lives_nxt == 4'd0)
        state_nxt = OVER;
      else if (state_q == BOSS && hp_nxt == 4'd0)
        state_nxt = WIN;
      else if (state_q == PLAY && kills_nxt >= 8'(BOSS_KILLS))
        state_nxt = BOSS;
    end

`ifdef GAME_FLOW_INVULN_EN
    grace_nxt = grace_q;
    if (state_nxt != PLAY && state_nxt != BOSS)
      grace_nxt = '0;
    else if (hit_ok)
      grace_nxt = 10'(INVULN_TICKS);
    else if (bus.tick && grace_q != '0)
      grace_nxt = grace_q - 10'd1;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      score_q   <= '0;
      lives_q   <= 4'(LIVES);
      hp_q      <= 4'(BOSS_HP);
      kills_q   <= '0;
      play_en_q <= 1'b0;
      boss_en_q <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      score_q   <= score_nxt;
      lives_q   <= lives_nxt;
      hp_q      <= hp_nxt;
      kills_q   <= kills_nxt;
      play_en_q <= (state_nxt == PLAY) || (state_nxt == BOSS);
      boss_en_q <= (state_nxt == BOSS);
    end
  end

`ifdef GAME_FLOW_INVULN_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      grace_q  <= '0;
      invuln_q <= 1'b0;
    end else begin
      grace_q  <= grace_nxt;
      invuln_q <= (grace_nxt != '0);
    end
  end
`endif

  assign bus.state   = state_q;
  assign bus.play_en = play_en_q;
  assign bus.boss_en = boss_en_q;
  assign bus.score   = score_q;
  assign bus.lives   = lives_q;
  assign bus.boss_hp = hp_q;
  assign bus.invuln  = invuln_q;
endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scoreboard bench for game_flow_ctrl.
// Expected snapshots are queued at stimulus time, checked on negedge.
module tb_game_flow_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  game_flow_ctrl_if #(.DIGITS(4)) bus ();

  game_flow_ctrl #(.DIGITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string      tag;
    int         due;
    logic [2:0] st;
    logic [15:0] sc;
    logic [3:0] lv;
    logic [3:0] hp;
    logic       inv;
  } exp_t;

  exp_t q[$];
  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;

`ifdef GAME_FLOW_INVULN_EN
  localparam logic INV_ON = 1'b1;
`else
  localparam logic INV_ON = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      chk({e.tag, ".state"}, 32'(bus.state), 32'(e.st));
      chk({e.tag, ".score"}, 32'(bus.score), 32'(e.sc));
      chk({e.tag, ".lives"}, 32'(bus.lives), 32'(e.lv));
      chk({e.tag, ".boss_hp"}, 32'(bus.boss_hp), 32'(e.hp));
      chk({e.tag, ".invuln"}, 32'(bus.invuln), 32'(e.inv));
      chk({e.tag, ".play_en"}, 32'(bus.play_en),
          32'(e.st == 3'd1 || e.st == 3'd2));
      chk({e.tag, ".boss_en"}, 32'(bus.boss_en), 32'(e.st == 3'd2));
    end
  end

  task automatic drive(input logic s, input logic k, input logic b,
                       input logic p, input logic c, input logic t);
    bus.start      = s;
    bus.enemy_kill = k;
    bus.boss_hit   = b;
    bus.player_hit = p;
    bus.collision  = c;
    bus.tick       = t;
    @(posedge clk);
    #1;
    bus.start      = 1'b0;
    bus.enemy_kill = 1'b0;
    bus.boss_hit   = 1'b0;
    bus.player_hit = 1'b0;
    bus.collision  = 1'b0;
    bus.tick       = 1'b0;
  endtask

  task automatic expect_st(input string tag, input logic [2:0] st,
                           input logic [15:0] sc, input logic [3:0] lv,
                           input logic [3:0] hp, input logic inv);
    exp_t e;
    e.tag = tag;
    e.due = cyc;
    e.st  = st;
    e.sc  = sc;
    e.lv  = lv;
    e.hp  = hp;
    e.inv = inv;
    q.push_back(e);
  endtask

  task automatic kills(input int n);
    repeat (n) drive(0, 1, 0, 0, 0, 0);
  endtask

  task automatic bhits(input int n);
    repeat (n) drive(0, 0, 1, 0, 0, 0);
  endtask

  task automatic ticks(input int n);
    repeat (n) drive(0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.enemy_kill = 1'b0;
    bus.boss_hit   = 1'b0;
    bus.player_hit = 1'b0;
    bus.collision  = 1'b0;
    bus.tick       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_st("reset", 3'd0, 16'h0000, 4'd3, 4'd8, 1'b0);
    rst = 1'b1;

    drive(0, 1, 1, 1, 1, 0);
    expect_st("idle_ignore", 3'd0, 16'h0000, 4'd3, 4'd8, 1'b0);
    drive(1, 0, 0, 0, 0, 0);
    expect_st("start", 3'd1, 16'h0000, 4'd3, 4'd8, 1'b0);
    drive(1, 0, 1, 0, 0, 0);
    expect_st("play_start_bhit", 3'd1, 16'h0000, 4'd3, 4'd8, 1'b0);
    kills(9);
    expect_st("kill9", 3'd1, 16'h0009, 4'd3, 4'd8, 1'b0);
    kills(1);
    expect_st("kill10", 3'd2, 16'h0010, 4'd3, 4'd8, 1'b0);
    bhits(7);
    expect_st("boss7", 3'd2, 16'h0045, 4'd3, 4'd1, 1'b0);
    bhits(1);
    expect_st("win", 3'd4, 16'h0050, 4'd3, 4'd0, 1'b0);
    drive(0, 1, 1, 1, 1, 0);
    expect_st("win_hold", 3'd4, 16'h0050, 4'd3, 4'd0, 1'b0);
    drive(1, 0, 0, 0, 0, 0);
    expect_st("win_idle", 3'd0, 16'h0050, 4'd3, 4'd0, 1'b0);
    drive(1, 0, 0, 0, 0, 0);
    expect_st("restart", 3'd1, 16'h0000, 4'd3, 4'd8, 1'b0);

    kills(10);
    expect_st("boss2", 3'd2, 16'h0010, 4'd3, 4'd8, 1'b0);
    drive(0, 1, 1, 0, 0, 0);
    expect_st("dual_add", 3'd2, 16'h0016, 4'd3, 4'd7, 1'b0);
    drive(0, 0, 0, 1, 0, 0);
    expect_st("hit1", 3'd2, 16'h0016, 4'd2, 4'd7, INV_ON);
    drive(0, 0, 0, 1, 0, 0);
`ifdef GAME_FLOW_INVULN_EN
    expect_st("hit2_ignored", 3'd2, 16'h0016, 4'd2, 4'd7, 1'b1);
    ticks(99);
    expect_st("tick99", 3'd2, 16'h0016, 4'd2, 4'd7, 1'b1);
    ticks(1);
    expect_st("tick100", 3'd2, 16'h0016, 4'd2, 4'd7, 1'b0);
    drive(0, 0, 0, 1, 0, 0);
    expect_st("hit3", 3'd2, 16'h0016, 4'd1, 4'd7, 1'b1);
    ticks(100);
    expect_st("grace2", 3'd2, 16'h0016, 4'd1, 4'd7, 1'b0);
`else
    expect_st("hit2", 3'd2, 16'h0016, 4'd1, 4'd7, 1'b0);
    ticks(100);
    expect_st("ticks", 3'd2, 16'h0016, 4'd1, 4'd7, 1'b0);
`endif
    bhits(5);
    expect_st("boss_hp2", 3'd2, 16'h0041, 4'd1, 4'd2, 1'b0);
    bhits(1);
    expect_st("boss_hp1", 3'd2, 16'h0046, 4'd1, 4'd1, 1'b0);
    drive(0, 0, 1, 1, 0, 0);
    expect_st("over_beats_win", 3'd3, 16'h0051, 4'd0, 4'd0, 1'b0);
    drive(0, 1, 1, 0, 0, 0);
    expect_st("over_hold", 3'd3, 16'h0051, 4'd0, 4'd0, 1'b0);
    drive(1, 0, 0, 0, 0, 0);
    expect_st("over_idle", 3'd0, 16'h0051, 4'd0, 4'd0, 1'b0);
    drive(1, 0, 0, 0, 0, 0);
    expect_st("restart2", 3'd1, 16'h0000, 4'd3, 4'd8, 1'b0);

    kills(999);
    expect_st("k999", 3'd2, 16'h0999, 4'd3, 4'd8, 1'b0);
    kills(1);
    expect_st("k1000", 3'd2, 16'h1000, 4'd3, 4'd8, 1'b0);
    kills(8990);
    expect_st("k9990", 3'd2, 16'h9990, 4'd3, 4'd8, 1'b0);
    kills(12);
    expect_st("sat_kill", 3'd2, 16'h9999, 4'd3, 4'd8, 1'b0);
    bhits(1);
    expect_st("sat_boss", 3'd2, 16'h9999, 4'd3, 4'd7, 1'b0);

    drive(0, 0, 0, 0, 1, 0);
    expect_st("coll_boss", 3'd3, 16'h9999, 4'd0, 4'd7, 1'b0);
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    expect_st("restart3", 3'd1, 16'h0000, 4'd3, 4'd8, 1'b0);
    drive(0, 0, 0, 0, 1, 0);
    expect_st("coll_play", 3'd3, 16'h0000, 4'd0, 4'd8, 1'b0);
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    kills(10);
    bhits(1);
    expect_st("pre_rst", 3'd2, 16'h0015, 4'd3, 4'd7, 1'b0);

    bus.enemy_kill = 1'b1;
    bus.boss_hit   = 1'b1;
    rst            = 1'b0;
    @(posedge clk);
    #1;
    bus.enemy_kill = 1'b0;
    bus.boss_hit   = 1'b0;
    expect_st("rst_mid_boss", 3'd0, 16'h0000, 4'd3, 4'd8, 1'b0);
    rst = 1'b1;

    @(negedge clk);
    #1;
    chk("drain", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end
endmodule
